// File: rtl/miss_mem_pkg.sv
// miss_mem_pkg: address split helpers, fill FSM states and default spawn masks for miss_mem_model
package miss_mem_pkg;
   typedef enum logic {IDLE, FILL} fill_state_t;
   localparam logic [63:0] CHILD_CFG_DEF = 64'h7FBFDFEFF7FBFDFE;
   function automatic logic [29:0] word_idx(input logic [31:0] addr);
      return 30'(addr >> 2);
   endfunction
   function automatic logic [29:0] line_num(input logic [29:0] word, input int lw);
      return word / 30'(lw);
   endfunction
   function automatic logic [29:0] entry_idx(input logic [29:0] line, input int nl);
      return line % 30'(nl);
   endfunction
   function automatic logic [29:0] line_tag(input logic [29:0] line, input int nl);
      return line / 30'(nl);
   endfunction
   function automatic int tag_w(input int lw, input int nl);
      return 30 - $clog2(lw) - $clog2(nl);
   endfunction
endpackage

// File: rtl/miss_fill_ctrl.sv
// miss_fill_ctrl: per-port line-presence table and fill engine that turns first touches into timed misses
module miss_fill_ctrl
   import miss_mem_pkg::*;
#(
   parameter int MISS_LAT   = 4,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [29:0] word,
   output logic        hit
);
   localparam int TW = tag_w(LINE_WORDS, NUM_LINES);
   localparam int EW = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
   localparam int CW = MISS_LAT > 1 ? $clog2(MISS_LAT) : 1;
   fill_state_t          state;
   logic [CW-1:0]        cnt;
   logic [29:0]          fill_line;
   logic [29:0]          line;
   logic [29:0]          inst_line;
   logic [NUM_LINES-1:0] vld;
   logic [TW-1:0]        tags [NUM_LINES];
   logic [EW-1:0]        ent;
   logic [EW-1:0]        inst_ent;
   logic [TW-1:0]        tag;
   logic [TW-1:0]        inst_tag;
   logic                 start;
   logic                 done;
   logic                 inst;
   assign line      = line_num(word, LINE_WORDS);
   assign ent       = EW'(entry_idx(line, NUM_LINES));
   assign tag       = TW'(line_tag(line, NUM_LINES));
   assign hit       = vld[ent] && tags[ent] == tag;
   assign start     = state == IDLE && req && !hit;
   assign done      = state == FILL && cnt == CW'(MISS_LAT - 1);
   // a one-cycle latency installs straight from the missing request
   assign inst      = done || (start && MISS_LAT == 1);
   assign inst_line = state == FILL ? fill_line : line;
   assign inst_ent  = EW'(entry_idx(inst_line, NUM_LINES));
   assign inst_tag  = TW'(line_tag(inst_line, NUM_LINES));
   // fill FSM: capture the missing line, count out the latency, then mark it present
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         fill_line <= '0;
         vld       <= '0;
      end else begin
         if (inst) vld[inst_ent] <= 1'b1;
         if (done) state <= IDLE;
         else if (state == FILL) cnt <= cnt + 1'b1;
         else if (start && MISS_LAT > 1) begin
            state     <= FILL;
            cnt       <= CW'(1);
            fill_line <= line;
         end
      end
   // tag store, written together with the valid bit on install
   always_ff @(posedge clk)
      if (inst) tags[inst_ent] <= inst_tag;
endmodule

// File: rtl/miss_mem_model.sv
// miss_mem_model: shared-array simulation memory for threadkraken_top with first-touch miss timing per port
// Define MISS_MEM_MISS_SIM_EN to compile in presence trackers and fill engines; otherwise every legal access hits.
module miss_mem_model
   import miss_mem_pkg::*;
#(
   parameter string       INIT_FILE  = "prog.o",
   parameter int          MEM_WORDS  = 16384,
   parameter int          MISS_LAT   = 4,
   parameter int          LINE_WORDS = 4,
   parameter int          NUM_LINES  = 16,
   parameter logic [63:0] CHILD_CFG  = CHILD_CFG_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_addr,
   input  logic        i_rd,
   input  logic [2:0]  i_trd,
   output logic [31:0] i_rd_data,
   output logic        i_miss,
   output logic        i_segfault,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wr_data,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [2:0]  d_trd,
   output logic [31:0] d_rd_data,
   output logic        d_miss,
   output logic        d_segfault,
   output logic [7:0]  child_0,
   output logic [7:0]  child_1,
   output logic [7:0]  child_2,
   output logic [7:0]  child_3,
   output logic [7:0]  child_4,
   output logic [7:0]  child_5,
   output logic [7:0]  child_6,
   output logic [7:0]  child_7,
   input  logic        alu_exp,
   input  logic [2:0]  alu_trd,
   input  logic        inv_op,
   input  logic [2:0]  inv_op_trd,
   input  logic [2:0]  insfetch_trd,
   input  logic        breakpoint,
   input  logic [2:0]  bp_trd,
   input  logic [7:0]  valid_trd,
   input  logic [7:0]  run_trd,
   input  logic        running,
   input  logic        trd_of,
   input  logic        trd_full
);
   localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
   logic [31:0] mem [MEM_WORDS];
   logic [29:0] i_word;
   logic [29:0] d_word;
   logic        i_bad;
   logic        d_bad;
   logic        i_ok;
   logic        d_ok;
   logic        i_hit;
   logic        d_hit;
   logic        unused_obs;
   assign unused_obs = ^{i_trd, d_trd, alu_exp, alu_trd, inv_op, inv_op_trd, insfetch_trd,
                         breakpoint, bp_trd, valid_trd, run_trd, running, trd_of, trd_full};
   assign i_word = word_idx(i_addr);
   assign d_word = word_idx(d_addr);
   assign i_bad  = i_addr[1:0] != 2'b0 || {2'b0, i_word} >= 32'(MEM_WORDS);
   assign d_bad  = d_addr[1:0] != 2'b0 || {2'b0, d_word} >= 32'(MEM_WORDS);
   assign i_ok   = rst_n && i_rd && !i_bad;
   assign d_ok   = rst_n && (d_rd || d_wr) && !d_bad;
`ifdef MISS_MEM_MISS_SIM_EN
   miss_fill_ctrl #(.MISS_LAT(MISS_LAT), .LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES)) u_i_fill (
      .clk(clk), .rst_n(rst_n), .req(i_ok), .word(i_word), .hit(i_hit));
   miss_fill_ctrl #(.MISS_LAT(MISS_LAT), .LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES)) u_d_fill (
      .clk(clk), .rst_n(rst_n), .req(d_ok), .word(d_word), .hit(d_hit));
`else
   assign i_hit = 1'b1;
   assign d_hit = 1'b1;
`endif
   assign i_miss     = i_ok && !i_hit;
   assign d_miss     = d_ok && !d_hit;
   assign i_segfault = rst_n && i_rd && i_bad;
   assign d_segfault = rst_n && (d_rd || d_wr) && d_bad;
   assign i_rd_data  = i_ok && i_hit ? mem[i_word[AW-1:0]] : '0;
   assign d_rd_data  = d_ok && d_hit ? mem[d_word[AW-1:0]] : '0;
   // store port: only a legal hit outside reset updates the array, so both ports see the old word this cycle
   always_ff @(posedge clk)
      if (d_wr && d_ok && d_hit) mem[d_word[AW-1:0]] <= d_wr_data;
   assign child_0 = CHILD_CFG[0+:8];
   assign child_1 = CHILD_CFG[8+:8];
   assign child_2 = CHILD_CFG[16+:8];
   assign child_3 = CHILD_CFG[24+:8];
   assign child_4 = CHILD_CFG[32+:8];
   assign child_5 = CHILD_CFG[40+:8];
   assign child_6 = CHILD_CFG[48+:8];
   assign child_7 = CHILD_CFG[56+:8];
endmodule

// File: tb/tb_miss_mem_model.sv
// tb_miss_mem_model: randomized and directed checks of miss_mem_model against a line-presence reference model
module tb_miss_mem_model;
`ifdef MISS_MEM_MISS_SIM_EN
   localparam bit SIM = 1'b1;
`else
   localparam bit SIM = 1'b0;
`endif
   localparam int LAT = 4;
   localparam int MW  = 16384;
   localparam int LW  = 4;
   localparam int NL  = 16;
   localparam int REG = 256;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wr_data = '0;
   logic        i_rd = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
   logic [2:0]  i_trd = '0, d_trd = '0;
   logic        alu_exp = 1'b0, inv_op = 1'b0, breakpoint = 1'b0, running = 1'b0, trd_of = 1'b0, trd_full = 1'b0;
   logic [2:0]  alu_trd = '0, inv_op_trd = '0, insfetch_trd = '0, bp_trd = '0;
   logic [7:0]  valid_trd = '0, run_trd = '0;
   logic [31:0] i_rd_data, d_rd_data;
   logic        i_miss, i_segfault, d_miss, d_segfault;
   logic [7:0]  ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7;
   int          total = 0, bad = 0;
   int          tagm [2][NL];
   bit          busy [2];
   int          fline [2];
   int          left [2];
   logic [31:0] mm [REG];
   int          imiss_n = 0, dmiss_n = 0;
   logic [31:0] s_idata, s_ddata;
   logic        s_imiss, s_iseg, s_dmiss, s_dseg;

   miss_mem_model #(.INIT_FILE("")) dut (
      .clk(clk), .rst_n(rst_n),
      .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd), .i_rd_data(i_rd_data), .i_miss(i_miss), .i_segfault(i_segfault),
      .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
      .d_rd_data(d_rd_data), .d_miss(d_miss), .d_segfault(d_segfault),
      .child_0(ch0), .child_1(ch1), .child_2(ch2), .child_3(ch3),
      .child_4(ch4), .child_5(ch5), .child_6(ch6), .child_7(ch7),
      .alu_exp(alu_exp), .alu_trd(alu_trd), .inv_op(inv_op), .inv_op_trd(inv_op_trd),
      .insfetch_trd(insfetch_trd), .breakpoint(breakpoint), .bp_trd(bp_trd),
      .valid_trd(valid_trd), .run_trd(run_trd), .running(running), .trd_of(trd_of), .trd_full(trd_full));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      return a[1:0] == 2'b0 && a < 32'(MW * 4);
   endfunction

   function automatic bit present(input int p, input int ln);
      return tagm[p][ln % NL] == ln;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         busy[p] = 1'b0;
         for (int e = 0; e < NL; e++) tagm[p][e] = -1;
      end
   endtask

   // a miss with an idle engine keeps missing for LAT cycles in total, then the line is present
   task automatic adv(input int p, input bit miss, input int ln);
      if (busy[p]) begin
         left[p]--;
         if (left[p] == 0) begin
            tagm[p][fline[p] % NL] = fline[p];
            busy[p] = 1'b0;
         end
      end else if (miss) begin
         if (LAT == 1) tagm[p][ln % NL] = ln;
         else begin
            busy[p] = 1'b1;
            fline[p] = ln;
            left[p] = LAT - 1;
         end
      end
   endtask

   // one clock cycle: inputs were set just after the previous edge; check mid-cycle, then advance the model
   task automatic cyc();
      int  iw, dw;
      bit  iok, dok, ihit, dhit, dreq;
      {alu_exp, alu_trd, inv_op, inv_op_trd, insfetch_trd, breakpoint, bp_trd, running, trd_of, trd_full} = 18'($urandom);
      valid_trd = 8'($urandom);
      run_trd = 8'($urandom);
      i_trd = 3'($urandom);
      d_trd = 3'($urandom);
      #2;
      dreq = d_rd || d_wr;
      iw = int'(i_addr >> 2);
      dw = int'(d_addr >> 2);
      iok = rst_n && i_rd && legal(i_addr);
      dok = rst_n && dreq && legal(d_addr);
      ihit = !SIM || present(0, iw / LW);
      dhit = !SIM || present(1, dw / LW);
      s_imiss = i_miss; s_iseg = i_segfault; s_idata = i_rd_data;
      s_dmiss = d_miss; s_dseg = d_segfault; s_ddata = d_rd_data;
      if (i_miss) imiss_n++;
      if (d_miss) dmiss_n++;
      chk("i_miss", i_miss, iok && !ihit);
      chk("i_seg", i_segfault, rst_n && i_rd && !legal(i_addr));
      chk("i_data", i_rd_data, (iok && ihit) ? mm[iw % REG] : 32'h0);
      chk("d_miss", d_miss, dok && !dhit);
      chk("d_seg", d_segfault, rst_n && dreq && !legal(d_addr));
      if (d_rd || !dreq) chk("d_data", d_rd_data, (dok && dhit) ? mm[dw % REG] : 32'h0);
      if (!rst_n) model_reset();
      else begin
         if (dok && dhit && d_wr) mm[dw % REG] = d_wr_data;
         adv(0, iok && !ihit, iw / LW);
         adv(1, dok && !dhit, dw / LW);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] a, input int n);
      idle();
      i_rd = 1'b1; i_addr = a;
      imiss_n = 0;
      repeat (n) cyc();
   endtask

   function automatic logic [31:0] raddr();
      int r, w;
      r = $urandom_range(0, 19);
      w = $urandom_range(0, REG - 1);
      if (r == 0) return 32'(w * 4 + $urandom_range(1, 3));
      if (r == 1) return 32'(MW * 4 + w * 4);
      return 32'(w * 4);
   endfunction

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      // requests held during reset must see all-zero outputs
      i_rd = 1'b1; i_addr = 32'h100; d_rd = 1'b1; d_addr = 32'h200;
      cyc();
      cyc();
      chk("rst_i_miss", s_imiss, 1'b0);
      chk("rst_d_data", s_ddata, 32'h0);
      rst_n = 1'b1;
      idle();
      // fill the checked region through the data port
      for (int w = 0; w < REG; w++) begin
         d_wr = 1'b1; d_addr = 32'(w * 4); d_wr_data = $urandom;
         repeat (LAT + 1) cyc();
      end
      d_wr = 1'b1; d_addr = 32'h100; d_wr_data = 32'hDEADBEEF;
      repeat (LAT + 1) cyc();
      // store then load on a line the data tracker does not hold
      d_addr = 32'h200; d_wr_data = 32'h12345678;
      dmiss_n = 0;
      repeat (LAT + 1) cyc();
      chk("st_miss_cycles", dmiss_n, SIM ? LAT : 0);
      d_wr = 1'b0; d_rd = 1'b1;
      cyc();
      chk("ld_after_st", s_ddata, 32'h12345678);
      chk("ld_after_st_miss", s_dmiss, 1'b0);
      // cold fetch
      do_reset();
      fetch(32'h100, LAT + 1);
      chk("cold_miss_cycles", imiss_n, SIM ? LAT : 0);
      chk("cold_data", s_idata, 32'hDEADBEEF);
      fetch(32'h104, 1);
      chk("same_line_hit", s_imiss, 1'b0);
      // segfaults
      idle();
      d_rd = 1'b1; d_addr = 32'h201;
      cyc();
      chk("d_seg_dir", s_dseg, 1'b1);
      chk("d_seg_miss", s_dmiss, 1'b0);
      chk("d_seg_data", s_ddata, 32'h0);
      fetch(32'(MW * 4), 1);
      chk("i_seg_dir", s_iseg, 1'b1);
      // conflict on entry 0: lines 0 and 16
      do_reset();
      fetch(32'h0, LAT + 2);
      fetch(32'h100, LAT + 1);
      chk("conflict_miss", imiss_n, SIM ? LAT : 0);
      fetch(32'h0, LAT + 1);
      chk("refetch_miss", imiss_n, SIM ? LAT : 0);
      // reset in the second miss cycle
      do_reset();
      fetch(32'h40, 1);
      rst_n = 1'b0;
      cyc();
      chk("midfill_rst_miss", s_imiss, 1'b0);
      chk("midfill_rst_data", s_idata, 32'h0);
      rst_n = 1'b1;
      fetch(32'h40, LAT + 1);
      chk("after_rst_miss", imiss_n, SIM ? LAT : 0);
      chk("child_3", ch3, 8'hF7);
      chk("child_7", ch7, 8'h7F);
      chk("child_0", ch0, 8'hFE);
      // random traffic with occasional reset pulses
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 1) == 1) i_addr = raddr();
         if ($urandom_range(0, 1) == 1) d_addr = raddr();
         i_rd = $urandom_range(0, 9) < 7;
         d_rd = $urandom_range(0, 1) == 1;
         d_wr = $urandom_range(0, 2) == 0;
         d_wr_data = $urandom;
         rst_n = $urandom_range(0, 99) != 0;
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
